// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: accepts one load/store, checks alignment and range,
// then drives the memory strobes for WAIT_CYCLES cycles and returns a response.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_BYTES   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_fault,
    output logic [31:0] rsp_rdata,
    output logic        MEM_W,
    output logic        MEM_R,
    output logic        MEM_S,
    output logic [1:0]  MEM_C,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned WC =
        (WAIT_CYCLES == 0) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0]  CNT_INIT = 4'(WC - 1);
    localparam logic [32:0] LIMIT    = 33'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ACCESS,
        S_FAULT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic        is_load;
    logic        misalign;
    logic        out_of_range;
    logic [32:0] end_addr;
    logic [32:0] size33;

    function automatic logic [1:0] size_of(input logic [2:0] op);
        logic [1:0] c;
        c = 2'b10;
        case (op)
            3'd0, 3'd5:       c = 2'b00;
            3'd1, 3'd2, 3'd6: c = 2'b01;
            default:          c = 2'b10;
        endcase
        return c;
    endfunction

    assign req_ready = (state == S_IDLE);
    assign is_load   = (op_q <= 3'd4);

    // Sum is 33 bits wide so an access near 0xFFFFFFFF cannot wrap into range.
    always_comb begin
        size33 = 33'd1;
        case (MEM_C)
            2'b00:   size33 = 33'd4;
            2'b01:   size33 = 33'd2;
            default: size33 = 33'd1;
        endcase
        end_addr     = {1'b0, mem_addr} + size33;
        out_of_range = end_addr > LIMIT;
        misalign     = ((MEM_C == 2'b00) && (mem_addr[1:0] != 2'b00)) ||
                       ((MEM_C == 2'b01) && mem_addr[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            op_q      <= 3'd0;
            MEM_W     <= 1'b0;
            MEM_R     <= 1'b0;
            MEM_S     <= 1'b0;
            MEM_C     <= 2'b00;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_CHECK;
                        op_q      <= req_op;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        MEM_C     <= size_of(req_op);
                        MEM_S     <= (req_op == 3'd1) || (req_op == 3'd3);
                        rsp_rdata <= 32'd0;
                    end
                end
                S_CHECK: begin
                    if (misalign || out_of_range) begin
                        state     <= S_FAULT;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                    end else begin
                        state <= S_ACCESS;
                        cnt   <= CNT_INIT;
                        MEM_R <= is_load;
                        MEM_W <= ~is_load;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        MEM_R     <= 1'b0;
                        MEM_W     <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (is_load) rsp_rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_FAULT: state <= S_IDLE;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3), each with a
// byte-addressed combinational memory model; table-driven plus reset sequence.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [2:0]  req_op    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_fault [2];
    logic [31:0] rsp_rdata [2];
    logic        mem_w     [2];
    logic        mem_r     [2];
    logic        mem_s     [2];
    logic [1:0]  mem_c     [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0]  mem [0:1023];
        logic [9:0]  a;
        logic [31:0] rd;

        mem_access_ctrl #(
            .WAIT_CYCLES((g == 0) ? 1 : 3),
            .MEM_BYTES  (1024)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_op   (req_op[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_fault(rsp_fault[g]),
            .rsp_rdata(rsp_rdata[g]),
            .MEM_W    (mem_w[g]),
            .MEM_R    (mem_r[g]),
            .MEM_S    (mem_s[g]),
            .MEM_C    (mem_c[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );

        assign a = mem_addr[g][9:0];

        always @(posedge clk) begin
            if (mem_w[g]) begin
                mem[a] <= mem_wdata[g][7:0];
                if (mem_c[g] != 2'b10) mem[a + 10'd1] <= mem_wdata[g][15:8];
                if (mem_c[g] == 2'b00) begin
                    mem[a + 10'd2] <= mem_wdata[g][23:16];
                    mem[a + 10'd3] <= mem_wdata[g][31:24];
                end
            end
        end

        always_comb begin
            rd = 32'd0;
            case (mem_c[g])
                2'b00: rd = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
                2'b01: rd = {{16{mem_s[g] & mem[a + 10'd1][7]}}, mem[a + 10'd1], mem[a]};
                default: rd = {{24{mem_s[g] & mem[a][7]}}, mem[a]};
            endcase
        end
        assign mem_rdata[g] = rd;

        always @(negedge clk) begin
            if (!rst[g] && mem_r[g] && mem_w[g]) begin
                bad++;
                $display("FAIL both_strobes inst=%0d actual=11 required=not both", g);
            end
        end
    end

    typedef struct {
        int          d;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        logic [1:0]  c;
        logic        s;
        int          poke;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic fault,
                       input logic [31:0] rdata, input logic [1:0] c,
                       input logic s, input int poke);
        vec_t v;
        v.d = d; v.op = op; v.addr = addr; v.wdata = wdata; v.fault = fault;
        v.rdata = rdata; v.c = c; v.s = s; v.poke = poke;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input string tag,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input vec_t v, input string nm);
        int w, rsp_at, first_s, n_s, k;
        logic ld;
        w  = (v.d == 0) ? 1 : 3;
        ld = (v.op <= 3'd4);
        k  = 0;
        while (!req_ready[v.d] && k < 50) begin
            cyc();
            k++;
        end
        chk(nm, "ready", 32'(req_ready[v.d]), 32'd1);
        req_op[v.d]    = v.op;
        req_addr[v.d]  = v.addr;
        req_wdata[v.d] = v.wdata;
        req_valid[v.d] = 1'b1;
        cyc();
        req_valid[v.d] = 1'b0;
        rsp_at = 0; first_s = 0; n_s = 0;
        for (int c = 1; c <= 30 && rsp_at == 0; c++) begin
            if (c == 1) begin
                chk(nm, "busy", 32'(req_ready[v.d]), 32'd0);
                chk(nm, "mem_c", 32'(mem_c[v.d]), 32'(v.c));
                chk(nm, "mem_s", 32'(mem_s[v.d]), 32'(v.s));
                chk(nm, "mem_addr", mem_addr[v.d], v.addr);
                chk(nm, "rdata_clr", rsp_rdata[v.d], 32'd0);
            end
            if (c == v.poke) begin
                req_op[v.d]    = 3'd0;
                req_addr[v.d]  = 32'd0;
                req_valid[v.d] = 1'b1;
                chk(nm, "poke_ready", 32'(req_ready[v.d]), 32'd0);
            end
            if (c == v.poke + 1) req_valid[v.d] = 1'b0;
            if (mem_r[v.d] || mem_w[v.d]) begin
                n_s++;
                if (first_s == 0) first_s = c;
                if (mem_r[v.d] != ld) begin
                    bad++;
                    $display("FAIL %s.dir actual=r%0d w%0d required=load%0d",
                             nm, mem_r[v.d], mem_w[v.d], ld);
                end
            end
            if (rsp_valid[v.d]) rsp_at = c;
            else cyc();
        end
        chk(nm, "latency", 32'(rsp_at), v.fault ? 32'd2 : 32'(w + 2));
        chk(nm, "strobe_n", 32'(n_s), v.fault ? 32'd0 : 32'(w));
        chk(nm, "strobe_at", 32'(first_s), v.fault ? 32'd0 : 32'd2);
        chk(nm, "fault", 32'(rsp_fault[v.d]), 32'(v.fault));
        chk(nm, "rdata", rsp_rdata[v.d], v.rdata);
        cyc();
        chk(nm, "pulse_end", 32'(rsp_valid[v.d]), 32'd0);
        chk(nm, "rdata_hold", rsp_rdata[v.d], v.rdata);
        chk(nm, "idle", 32'(req_ready[v.d]), 32'd1);
    endtask

    initial begin
        string nm;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; req_valid[g] = 1'b0; req_op[g] = 3'd0;
            req_addr[g] = 32'd0; req_wdata[g] = 32'd0;
        end
        //  d  op    addr          wdata         flt rdata         c      s  poke
        add(0, 3'd5, 32'h10,       32'h12345678, 0, 32'h0,        2'b00, 0, 0);
        add(0, 3'd0, 32'h10,       32'h0,        0, 32'h12345678, 2'b00, 0, 0);
        add(0, 3'd2, 32'h10,       32'h0,        0, 32'h00005678, 2'b01, 0, 0);
        add(0, 3'd1, 32'h12,       32'h0,        0, 32'h00001234, 2'b01, 1, 0);
        add(0, 3'd7, 32'h20,       32'h80,       0, 32'h0,        2'b10, 0, 0);
        add(0, 3'd3, 32'h20,       32'h0,        0, 32'hFFFFFF80, 2'b10, 1, 0);
        add(0, 3'd4, 32'h20,       32'h0,        0, 32'h00000080, 2'b10, 0, 0);
        add(0, 3'd0, 32'h22,       32'h0,        1, 32'h0,        2'b00, 0, 0);
        add(0, 3'd6, 32'h23,       32'h0,        1, 32'h0,        2'b01, 0, 0);
        add(0, 3'd5, 32'h3FC,      32'hA5A55A5A, 0, 32'h0,        2'b00, 0, 0);
        add(0, 3'd0, 32'h3FC,      32'h0,        0, 32'hA5A55A5A, 2'b00, 0, 0);
        add(0, 3'd1, 32'h3FE,      32'h0,        0, 32'hFFFFA5A5, 2'b01, 1, 0);
        add(0, 3'd4, 32'h3FF,      32'h0,        0, 32'h000000A5, 2'b10, 0, 0);
        add(0, 3'd0, 32'h400,      32'h0,        1, 32'h0,        2'b00, 0, 0);
        add(0, 3'd3, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        2'b10, 1, 0);
        add(0, 3'd6, 32'h3FF,      32'h0,        1, 32'h0,        2'b01, 0, 0);
        add(1, 3'd5, 32'h44,       32'hCAFEF00D, 0, 32'h0,        2'b00, 0, 0);
        add(1, 3'd6, 32'h40,       32'h0000BEEF, 0, 32'h0,        2'b01, 0, 3);
        add(1, 3'd2, 32'h40,       32'h0,        0, 32'h0000BEEF, 2'b01, 0, 0);
        add(1, 3'd1, 32'h40,       32'h0,        0, 32'hFFFFBEEF, 2'b01, 1, 0);
        add(1, 3'd0, 32'h41,       32'h0,        1, 32'h0,        2'b00, 0, 0);

        cyc(); cyc();
        for (int g = 0; g < 2; g++) rst[g] = 1'b0;
        cyc();
        for (int g = 0; g < 2; g++) begin
            nm = $sformatf("reset%0d", g);
            chk(nm, "ready", 32'(req_ready[g]), 32'd1);
            chk(nm, "strobes", {30'd0, mem_r[g], mem_w[g]}, 32'd0);
            chk(nm, "mem_s_c", {29'd0, mem_s[g], mem_c[g]}, 32'd0);
            chk(nm, "mem_addr", mem_addr[g], 32'd0);
            chk(nm, "mem_wdata", mem_wdata[g], 32'd0);
            chk(nm, "rsp", {30'd0, rsp_valid[g], rsp_fault[g]}, 32'd0);
            chk(nm, "rdata", rsp_rdata[g], 32'd0);
        end

        foreach (tbl[i]) begin
            nm = $sformatf("v%0d", i);
            txn(tbl[i], nm);
            if (tbl[i].poke != 0) begin
                for (int c = 0; c < 4; c++) begin
                    chk(nm, "no_extra", {30'd0, rsp_valid[tbl[i].d],
                        mem_r[tbl[i].d] | mem_w[tbl[i].d]}, 32'd0);
                    cyc();
                end
            end
        end

        // Abort a WAIT_CYCLES=3 load in its third cycle with an async reset.
        req_op[1] = 3'd0; req_addr[1] = 32'h44; req_valid[1] = 1'b1;
        cyc();
        req_valid[1] = 1'b0;
        cyc(); cyc();
        chk("rst_mid", "in_access", 32'(mem_r[1]), 32'd1);
        rst[1] = 1'b1;
        #1;
        chk("rst_mid", "strobe", {30'd0, mem_r[1], mem_w[1]}, 32'd0);
        chk("rst_mid", "rsp", 32'(rsp_valid[1]), 32'd0);
        chk("rst_mid", "idle", 32'(req_ready[1]), 32'd1);
        cyc();
        rst[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("rst_mid", "no_rsp", {30'd0, rsp_valid[1], mem_r[1]}, 32'd0);
            cyc();
        end
        txn('{1, 3'd0, 32'h44, 32'h0, 1'b0, 32'hCAFEF00D, 2'b00, 1'b0, 0}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the data memory port. Takes one load/store request per transaction from the multicycle control FSM.
- Checks alignment and range, then drives the memory strobe/size/sign/address/data signals for a fixed number of cycles. Captures load data and returns a one-cycle response.
- Sits between the control FSM/datapath and the byte-addressed data memory, which is a combinational responder.

Parameters:
- WAIT_CYCLES, 1: cycles the MEM_R/MEM_W strobe is held per access; legal range 1..15.
- MEM_BYTES, 1024: size of the memory window in bytes; any byte of an access at or above this faults.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  control FSM presents a request.
- req_ready  out  1  block idle and able to accept; equals (state==IDLE).
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (SH uses [15:0], SB uses [7:0]).
- rsp_valid  out  1  one-cycle pulse: transaction finished.
- rsp_fault  out  1  qualifies rsp_valid: misaligned or out-of-range, no memory access made.
- rsp_rdata  out  32  load result, already extended by memory; 0 for stores and faults.
- MEM_W  out  1  memory write strobe.
- MEM_R  out  1  memory read strobe.
- MEM_S  out  1  sign-extend select: 1 for LH and LB only.
- MEM_C  out  2  size: 00 word, 01 half, 10 byte; 11 never driven.
- mem_addr  out  32  byte address to memory.
- mem_wdata  out  32  store data to memory.
- mem_rdata  in  32  read data from memory (combinational).

Behaviour:
- Reset (async, immediate): state=IDLE; MEM_W=MEM_R=MEM_S=0; MEM_C=00; mem_addr=mem_wdata=0; rsp_valid=rsp_fault=0; rsp_rdata=0; wait counter=0.
- States:
  - IDLE -> CHECK on req_valid && req_ready.
  - CHECK -> FAULT or ACCESS.
  - ACCESS -> RESP when the counter reaches 0.
  - FAULT -> IDLE.
  - RESP -> IDLE.
- Accept (IDLE, req_valid=1):
  - Register op, addr and wdata.
  - Set MEM_C, MEM_S, mem_addr and mem_wdata.
  - These outputs then hold stable until the next accept.
- CHECK (1 cycle, no strobes): fault when any of the following holds:
  - word op and addr[1:0]!=0;
  - half op and addr[0]!=0;
  - addr + size > MEM_BYTES, computed 33-bit so there is no wrap at 0xFFFFFFFF.
- FAULT (1 cycle):
  - rsp_valid=1, rsp_fault=1, rsp_rdata=0.
  - MEM_R and MEM_W never asserted during the whole transaction.
- ACCESS (exactly WAIT_CYCLES cycles):
  - MEM_R=1 for loads, or MEM_W=1 for stores; never both.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - On the last ACCESS cycle of a load, rsp_rdata <= mem_rdata.
- RESP (1 cycle): strobes low, rsp_valid=1, rsp_fault=0. rsp_rdata holds the captured value (load) or 0 (store).
- rsp_rdata holds its value until the next accept, then clears to 0.
- Latency, accept edge = cycle 0:
  - normal access: CHECK at cycle 1, ACCESS cycles 2..WAIT_CYCLES+1, RESP at cycle WAIT_CYCLES+2;
  - fault: FAULT at cycle 2.
  - Minimum spacing between accepts is WAIT_CYCLES+3 cycles.
- Ordering invariants:
  - mem_addr, MEM_C and mem_wdata change only in IDLE, while strobes are low.
  - Strobes rise no earlier than one cycle after the address is set, and fall at least one cycle before it changes.
- Busy: req_valid while not IDLE is ignored; the request must be held by the requester until req_ready.
- Reset mid-ACCESS: strobes drop asynchronously. No rsp_valid is produced for the aborted transaction.
- Illegal WAIT_CYCLES=0 is treated as 1.

Test Plan:
- Word store/load, WAIT_CYCLES=1: SW addr=0x10 wdata=0x12345678, then LW 0x10.
  - SW: MEM_W high exactly cycle 2, RESP cycle 3 with rdata 0.
  - LW: rsp_rdata=0x12345678 at its RESP.
- Sign handling: preload byte 0x20=0x80.
  - LB 0x20 -> 0xFFFFFF80, MEM_S=1.
  - LBU 0x20 -> 0x00000080, MEM_S=0, MEM_C=10.
- Misalignment: LW 0x22, SH 0x23.
  - Each gives rsp_valid+rsp_fault at cycle 2 with rsp_rdata=0.
  - MEM_R and MEM_W stay 0 throughout (checked by assertion).
- Range: with MEM_BYTES=1024:
  - LW 0x3FC succeeds;
  - LW 0x400 faults;
  - LB 0xFFFFFFFF faults with no wrap.
- Wait states, WAIT_CYCLES=3: SH 0x40 data 0xBEEF.
  - MEM_W high cycles 2-4, RESP cycle 5.
  - req_valid pulsed during cycle 3 is ignored (req_ready=0).
  - LHU 0x40 -> 0x0000BEEF.
- Async reset: assert rst in cycle 3 of a WAIT_CYCLES=3 load.
  - Strobes and rsp_valid are 0 in the same cycle, state is IDLE, no response pulse.
  - The next LW completes normally.
